veldt_fv_mem_env: RTL
=====================

// Module: veldt_fv_mem_env
// PURPOSE
//  Parametrised formal/sim memory environment for the Veldt core. Sits in rvfi_wrapper between the core's RAM port and
//  solver-driven free inputs. Replaces the single-cycle free ramOut with an in-order, multi-outstanding responder.
//  Adds configurable latency, bounded random stalls and optional read-after-write coherence via a shadow table.
//  Flags requester protocol violations.
// PARAMETERS
//  ADDR_W     32  request address width
//  DATA_W     32  data width; multiple of 8
//  DEPTH      4   max outstanding requests; power of 2, >=2
//  LATENCY    1   min cycles from accept to rsp_valid; >=1
//  MAX_STALL  3   max consecutive honoured rand_stall cycles per response; 0 disables stalls
//  SHADOW_EN  1   1: reads of previously written addresses return shadow data; 0: always rand_rdata
//  SHADOW_AW  4   shadow index bits (2**SHADOW_AW entries, indexed by req_addr[SHADOW_AW+1:2])
// PORTS
//  clock        in   1           sole clock, rising edge
//  reset        in   1           synchronous, active-high
//  req_valid    in   1           core request valid
//  req_ready    out  1           = (outstanding < DEPTH); no full-bypass
//  req_we       in   1           1 write, 0 read
//  req_addr     in   ADDR_W      word address (bits [1:0] ignored)
//  req_wdata    in   DATA_W      write data
//  req_mask     in   DATA_W/8    byte write enables
//  rsp_valid    out  1           response valid (registered)
//  rsp_ready    in   1           core accepts response
//  rsp_rdata    out  DATA_W      read data; 0 for write acks
//  rand_stall   in   1           free input: request stall of eligible head
//  rand_rdata   in   DATA_W      free input: data for non-shadowed reads
//  outstanding  out  $clog2(DEPTH)+1  accepted-not-retired count
//  proto_err    out  1           sticky requester-violation flag
// BEHAVIOUR
//  Reset: rsp_valid=0, rsp_rdata=0, outstanding=0, proto_err=0, stall_run=0, all shadow valid bits cleared.
//   In-flight entries are discarded, including on reset mid-operation. req_ready=1 in the first cycle after reset.
//  Accept: req_valid&&req_ready. Push {we,rdata} into a circular FIFO; the entry's age counter starts at 0 and saturates at LATENCY.
//  Read data is fixed at accept, in this order:
//   1. SHADOW_EN, shadow[idx] valid and stored tag==req_addr[ADDR_W-1:2] -> shadow data;
//   2. otherwise rand_rdata sampled that cycle.
//  Write accept: shadow[idx] <= byte-merge(old,req_wdata,req_mask) when valid&&tag match, else req_wdata masked over 0.
//   Set valid and tag. Write response rdata=0.
//  Eligibility: head entry eligible when age>=LATENCY. Request accepted in cycle t is earliest visible on rsp_valid in t+LATENCY.
//  Stall: while head eligible and rsp_valid=0, rand_stall=1 with stall_run<MAX_STALL holds rsp_valid low and increments stall_run.
//   At stall_run==MAX_STALL, rand_stall is ignored. stall_run clears on retire.
//  Hold: once rsp_valid=1 it stays 1 with rsp_rdata stable until rsp_valid&&rsp_ready (retire, pop). Stalls never drop it.
//  Retire: next entry may raise rsp_valid the cycle after retire if already eligible (no bubble beyond register stage).
//  Simultaneous accept+retire: outstanding unchanged. When full, req_ready=0 even if retiring that cycle.
//  Wrap: read/write pointers wrap modulo DEPTH; outstanding ranges 0..DEPTH.
//  Empty: rsp_valid=0; rand_stall and rand_rdata ignored.
//  proto_err: set one cycle after the requester misbehaves, never cleared except by reset. Triggers:
//   - cycle N had req_valid&&!req_ready and in cycle N+1 req_valid dropped or any req_* field changed;
//   - rsp_ready is don't-care when rsp_valid=0 and never triggers it.
//  Order: responses strictly in accept order; read-after-write to the same address observes the write (SHADOW_EN=1).
// TESTING
//  LATENCY=1, no stall: read A at t -> rsp_valid at t+1, rsp_rdata=rand_rdata sampled at t; outstanding 1->0 on retire.
//  Write 0xDEADBEEF mask 4'b1111 to 0x40, then write 0x000000AA mask 4'b0001 to 0x40, then read 0x40.
//   -> read returns 0xDEADBEAA regardless of rand_rdata.
//  DEPTH=4, rsp_ready=0, 5 back-to-back requests -> 4 accepted; req_ready=0 while outstanding=4.
//   Then rsp_ready=1 -> 4 in-order responses; 5th accepted after first retire.
//  MAX_STALL=3, rand_stall held 1 -> rsp_valid rises exactly 3 cycles after eligibility.
//   rand_stall toggled after rsp_valid=1 -> rsp_valid stays high, data stable.
//  req_valid=1 with full FIFO, addr changed next cycle -> proto_err=1 next cycle and stays 1 until reset.
//  reset asserted with 3 outstanding -> next cycle outstanding=0, rsp_valid=0.
//   Read of previously written address returns rand_rdata (shadow cleared).

Source files
------------

// File: rtl/veldt_fv_mem_env.sv
// In-order, multi-outstanding memory responder for the Veldt core formal/sim harness.
// Adds latency, bounded stalls, a read-after-write shadow table and requester protocol checking.
module veldt_fv_mem_env #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 4,
    parameter int LATENCY   = 1,
    parameter int MAX_STALL = 3,
    parameter int SHADOW_EN = 1,
    parameter int SHADOW_AW = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [ADDR_W-1:0]      req_addr,
    input  logic [DATA_W-1:0]      req_wdata,
    input  logic [DATA_W/8-1:0]    req_mask,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DATA_W-1:0]      rsp_rdata,
    input  logic                   rand_stall,
    input  logic [DATA_W-1:0]      rand_rdata,
    output logic [$clog2(DEPTH):0] outstanding,
    output logic                   proto_err
);

    localparam int PW     = $clog2(DEPTH);
    localparam int CW     = PW + 1;
    localparam int AGW    = $clog2(LATENCY + 1);
    localparam int SW     = (MAX_STALL > 0) ? $clog2(MAX_STALL + 1) : 1;
    localparam int NB     = DATA_W / 8;
    localparam int TAG_W  = ADDR_W - 2;
    localparam int SH_N   = 1 << SHADOW_AW;
    localparam int HOLD_W = 1 + ADDR_W + DATA_W + NB;

    localparam logic [CW-1:0]  DEPTH_V = CW'(DEPTH);
    localparam logic [AGW-1:0] LAT_V   = AGW'(LATENCY);
    localparam logic [SW-1:0]  MAXS_V  = SW'(MAX_STALL);

    logic [PW-1:0]               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, cand_idx;
    logic [CW-1:0]               count_q, count_d, count_after_pop;
    logic [DEPTH-1:0][AGW-1:0]   age_q, age_d;
    logic [DATA_W-1:0]           fifo_rdata_q [DEPTH];

    logic [SH_N-1:0]             sh_valid_q, sh_valid_d;
    logic [TAG_W-1:0]            sh_tag_q [SH_N];
    logic [DATA_W-1:0]           sh_data_q [SH_N];
    logic [SHADOW_AW-1:0]        sh_idx;
    logic [TAG_W-1:0]            req_tag;
    logic                        sh_hit, sh_wr;
    logic [DATA_W-1:0]           sh_merge, acc_rdata;

    logic                        rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]           rsp_rdata_q, rsp_rdata_d;
    logic [SW-1:0]               stall_run_q, stall_run_d, stall_base;

    logic                        stalled_q, stalled_d;
    logic [HOLD_W-1:0]           hold_q, hold_d;
    logic                        proto_err_q, proto_err_d;

    logic                        accept, retire, cand_valid, cand_elig;
    logic [DATA_W-1:0]           cand_rdata;

    assign req_ready   = (count_q < DEPTH_V);
    assign accept      = req_valid && req_ready;
    assign retire      = rsp_valid_q && rsp_ready;
    assign sh_idx      = req_addr[SHADOW_AW+1:2];
    assign req_tag     = req_addr[ADDR_W-1:2];
    assign sh_hit      = (SHADOW_EN != 0) && sh_valid_q[sh_idx] && (sh_tag_q[sh_idx] == req_tag);
    assign sh_wr       = accept && req_we && (SHADOW_EN != 0);

    // Byte merge: unmasked bytes keep the old shadow word on a hit, zero otherwise.
    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_merge
            assign sh_merge[gi*8 +: 8] = req_mask[gi] ? req_wdata[gi*8 +: 8]
                                       : (sh_hit ? sh_data_q[sh_idx][gi*8 +: 8] : 8'h00);
        end
        // Age is the cycle count since accept: the accept cycle is 0, so the stored value starts at 1.
        for (gi = 0; gi < DEPTH; gi++) begin : g_age
            assign age_d[gi] = (accept && (wr_ptr_q == PW'(gi))) ? AGW'(1)
                             : ((age_q[gi] < LAT_V) ? age_q[gi] + 1'b1 : age_q[gi]);
        end
    endgenerate

    always_comb begin
        // Write acks carry zero data, so the FIFO only needs the response word.
        acc_rdata       = req_we ? '0 : (sh_hit ? sh_data_q[sh_idx] : rand_rdata);
        sh_valid_d      = sh_valid_q;
        if (sh_wr) begin
            sh_valid_d[sh_idx] = 1'b1;
        end

        wr_ptr_d        = accept ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d        = retire ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d         = count_q + CW'(accept) - CW'(retire);
        count_after_pop = count_q - CW'(retire);

        // Head for the next cycle; when nothing remains it is the slot being filled now.
        cand_idx   = rd_ptr_d;
        cand_valid = (count_after_pop != '0) || accept;
        cand_elig  = (age_d[cand_idx] >= LAT_V);
        cand_rdata = (count_after_pop != '0) ? fifo_rdata_q[cand_idx] : acc_rdata;

        stall_base  = retire ? '0 : stall_run_q;
        stall_run_d = stall_base;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        if (rsp_valid_q && !rsp_ready) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = rsp_rdata_q;
        end else if (cand_valid && cand_elig) begin
            if (rand_stall && (stall_base < MAXS_V)) begin
                stall_run_d = stall_base + 1'b1;
            end else begin
                rsp_valid_d = 1'b1;
                rsp_rdata_d = cand_rdata;
            end
        end

        // A refused request must be held unchanged until it is accepted.
        hold_d      = {req_we, req_addr, req_wdata, req_mask};
        stalled_d   = req_valid && !req_ready;
        proto_err_d = proto_err_q || (stalled_q && (!req_valid || (hold_d != hold_q)));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            age_q       <= '0;
            sh_valid_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            stall_run_q <= '0;
            stalled_q   <= 1'b0;
            hold_q      <= '0;
            proto_err_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            age_q       <= age_d;
            sh_valid_q  <= sh_valid_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            stall_run_q <= stall_run_d;
            stalled_q   <= stalled_d;
            hold_q      <= hold_d;
            proto_err_q <= proto_err_d;
        end
    end

    // Storage arrays carry no reset; pointers and valid bits gate their contents.
    always_ff @(posedge clock) begin
        if (accept) begin
            fifo_rdata_q[wr_ptr_q] <= acc_rdata;
        end
        if (sh_wr) begin
            sh_tag_q[sh_idx]  <= req_tag;
            sh_data_q[sh_idx] <= sh_merge;
        end
    end

    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign outstanding = count_q;
    assign proto_err   = proto_err_q;

endmodule
